// File: rtl/mem_stage_lsu.sv
// Memory-access stage: waits for the load/store response, aligns and extends load data for WB.
// Define MS_FWD_EN to drive real forward data to decode instead of stalling on every writer.
module mem_stage_lsu #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          es_to_ms_valid,
    output logic          ms_allowin,
    input  logic [DW-1:0] es_pc,
    input  logic [RW-1:0] es_dest,
    input  logic          es_gr_we,
    input  logic          es_res_from_mem,
    input  logic          es_mem_req,
    input  logic [4:0]    es_load_op,
    input  logic [DW-1:0] es_result,
    input  logic          es_ex,
    input  logic          data_sram_data_ok,
    input  logic [DW-1:0] data_sram_rdata,
    input  logic          ms_flush,
    input  logic          ws_allowin,
    output logic          ms_to_ws_valid,
    output logic [DW-1:0] ms_pc,
    output logic [RW-1:0] ms_dest,
    output logic          ms_gr_we,
    output logic [DW-1:0] ms_final_result,
    output logic          ms_ex,
    output logic          ms_fwd_valid,
    output logic          ms_blk_valid,
    output logic [RW-1:0] ms_fwd_dest,
    output logic [DW-1:0] ms_fwd_data
);

    logic          ms_valid;
    logic          ms_ready_go;
    logic [DW-1:0] pc_r;
    logic [RW-1:0] dest_r;
    logic          gr_we_r;
    logic          res_from_mem_r;
    logic          mem_req_r;
    logic [4:0]    load_op_r;
    logic [DW-1:0] result_r;
    logic          es_ex_r;
    logic          data_got;
    logic [DW-1:0] data_buf;
    logic [1:0]    cancel_cnt;

    logic          take;
    logic          leave;
    logic          resp_live;
    logic          inc_a;
    logic          inc_b;
    logic          dec;
    logic [2:0]    cnt_sum;
    logic [1:0]    cnt_next;
    logic [DW-1:0] ld_data;
    logic [1:0]    a;
    logic [7:0]    sel_b;
    logic [15:0]   sel_h;
    logic [DW-1:0] ext;

    assign resp_live   = data_sram_data_ok && (cancel_cnt == 2'd0);
    assign ms_ready_go = !mem_req_r || es_ex_r || data_got || resp_live;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign take        = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    assign leave       = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid       <= 1'b0;
            pc_r           <= '0;
            dest_r         <= '0;
            gr_we_r        <= 1'b0;
            res_from_mem_r <= 1'b0;
            mem_req_r      <= 1'b0;
            load_op_r      <= '0;
            result_r       <= '0;
            es_ex_r        <= 1'b0;
        end else begin
            if (ms_flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (take) begin
                pc_r           <= es_pc;
                dest_r         <= es_dest;
                gr_we_r        <= es_gr_we;
                res_from_mem_r <= es_res_from_mem;
                mem_req_r      <= es_mem_req;
                load_op_r      <= es_load_op;
                result_r       <= es_result;
                es_ex_r        <= es_ex;
            end
        end
    end

    // Hold a response that arrives while WB is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_got <= 1'b0;
            data_buf <= '0;
        end else if (ms_flush || take || leave) begin
            data_got <= 1'b0;
        end else if (resp_live && ms_valid && mem_req_r
                     && !data_got && !ws_allowin) begin
            data_got <= 1'b1;
            data_buf <= data_sram_rdata;
        end
    end

    // Count responses owed to flushed requests so they are dropped on arrival.
    assign inc_a = ms_flush && ms_valid && mem_req_r
                   && !data_got && !data_sram_data_ok;
    assign inc_b = ms_flush && es_to_ms_valid && es_mem_req;
    assign dec   = data_sram_data_ok && (cancel_cnt != 2'd0);

    always_comb begin
        cnt_sum = {1'b0, cancel_cnt} + {2'b0, inc_a}
                + {2'b0, inc_b} - {2'b0, dec};
        cnt_next = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            cancel_cnt <= 2'd0;
        else
            cancel_cnt <= cnt_next;
    end

    assign ld_data = data_got ? data_buf : data_sram_rdata;
    assign a       = result_r[1:0];

    always_comb begin
        sel_b = ld_data[7:0];
        unique case (a)
            2'd0: sel_b = ld_data[7:0];
            2'd1: sel_b = ld_data[15:8];
            2'd2: sel_b = ld_data[23:16];
            2'd3: sel_b = ld_data[31:24];
        endcase
        sel_h = a[1] ? ld_data[31:16] : ld_data[15:0];
    end

    always_comb begin
        ext = ld_data;
        unique case (1'b1)
            load_op_r[0]: ext = {{(DW-8){sel_b[7]}}, sel_b};
            load_op_r[1]: ext = {{(DW-16){sel_h[15]}}, sel_h};
            load_op_r[2]: ext = ld_data;
            load_op_r[3]: ext = {{(DW-8){1'b0}}, sel_b};
            load_op_r[4]: ext = {{(DW-16){1'b0}}, sel_h};
            default:      ext = ld_data;
        endcase
    end

    assign ms_pc           = pc_r;
    assign ms_dest         = dest_r;
    assign ms_gr_we        = gr_we_r;
    assign ms_final_result = res_from_mem_r ? ext : result_r;
    assign ms_ex           = ms_valid && es_ex_r;
    assign ms_fwd_dest     = dest_r;

`ifdef MS_FWD_EN
    assign ms_fwd_valid = ms_to_ws_valid && gr_we_r;
    assign ms_blk_valid = ms_valid && res_from_mem_r && !ms_ready_go;
    assign ms_fwd_data  = ms_final_result;
`else
    assign ms_fwd_valid = 1'b0;
    assign ms_blk_valid = ms_valid && gr_we_r;
    assign ms_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: load extension, buffering, flush drop, forwarding.
// Build with or without MS_FWD_EN; forward checks follow the macro.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_res_from_mem;
    logic        es_mem_req;
    logic [4:0]  es_load_op;
    logic [31:0] es_result;
    logic        es_ex;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic [31:0] ms_final_result;
    logic        ms_ex;
    logic        ms_fwd_valid;
    logic        ms_blk_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_res_from_mem(es_res_from_mem), .es_mem_req(es_mem_req),
        .es_load_op(es_load_op), .es_result(es_result), .es_ex(es_ex),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .ms_flush(ms_flush), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
        .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_final_result(ms_final_result), .ms_ex(ms_ex),
        .ms_fwd_valid(ms_fwd_valid), .ms_blk_valid(ms_blk_valid),
        .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res,
                         input logic req, input logic ld,
                         input logic [4:0] op, input logic ex);
        es_to_ms_valid  = 1'b1;
        es_pc           = pc;
        es_dest         = 5'd7;
        es_gr_we        = 1'b1;
        es_result       = res;
        es_mem_req      = req;
        es_res_from_mem = ld;
        es_load_op      = op;
        es_ex           = ex;
        tick();
        es_to_ms_valid  = 1'b0;
        es_ex           = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 0; es_pc = 0; es_dest = 0; es_gr_we = 0;
        es_res_from_mem = 0; es_mem_req = 0; es_load_op = 0;
        es_result = 0; es_ex = 0; data_sram_data_ok = 0;
        data_sram_rdata = 0; ms_flush = 0; ws_allowin = 1;
        tick();
        tick();
        chk("rst_allowin", {31'b0, ms_allowin}, 32'd1);
        chk("rst_to_ws", {31'b0, ms_to_ws_valid}, 32'd0);
        chk("rst_result", ms_final_result, 32'h0);
        chk("rst_blk", {31'b0, ms_blk_valid}, 32'd0);
        reset = 1'b0;
        tick();

        // ld.b at offset 3, response two cycles after capture
        issue(32'h100, 32'h1003, 1'b1, 1'b1, 5'b00001, 1'b0);
        settle();
        chk("ldb_wait_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        chk("ldb_wait_allowin", {31'b0, ms_allowin}, 32'd0);
        chk("ldb_blk", {31'b0, ms_blk_valid}, 32'd1);
        chk("ldb_fwd_pending", {31'b0, ms_fwd_valid}, 32'd0);
        tick();
        chk("ldb_wait2_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80112233;
        settle();
        chk("ldb_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("ldb_result", ms_final_result, 32'hFFFFFF80);
        chk("ldb_pc", ms_pc, 32'h100);
        chk("ldb_dest", {27'b0, ms_dest}, 32'd7);
`ifdef MS_FWD_EN
        chk("ldb_fwd_valid", {31'b0, ms_fwd_valid}, 32'd1);
        chk("ldb_fwd_data", ms_fwd_data, 32'hFFFFFF80);
        chk("ldb_blk_done", {31'b0, ms_blk_valid}, 32'd0);
`else
        chk("ldb_fwd_off", {31'b0, ms_fwd_valid}, 32'd0);
        chk("ldb_fwd_data_off", ms_fwd_data, 32'h0);
`endif
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("ldb_gone", {31'b0, ms_to_ws_valid}, 32'd0);
        chk("ldb_allowin", {31'b0, ms_allowin}, 32'd1);

        // ld.hu upper half
        issue(32'h104, 32'h2002, 1'b1, 1'b1, 5'b10000, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF1234;
        settle();
        chk("ldhu_result", ms_final_result, 32'h0000BEEF);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.h sign extend, lower half
        issue(32'h108, 32'h2000, 1'b1, 1'b1, 5'b00010, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000A5A5;
        settle();
        chk("ldh_result", ms_final_result, 32'hFFFFA5A5);
        tick();
        data_sram_data_ok = 1'b0;

        // response while WB stalls is buffered
        issue(32'h10C, 32'h3000, 1'b1, 1'b1, 5'b00100, 1'b0);
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEF00D;
        settle();
        chk("buf_valid0", {31'b0, ms_to_ws_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'hDEADBEEF;
            settle();
            chk("buf_valid", {31'b0, ms_to_ws_valid}, 32'd1);
            chk("buf_result", ms_final_result, 32'hCAFEF00D);
        end
        ws_allowin = 1'b1;
        settle();
        chk("buf_allowin", {31'b0, ms_allowin}, 32'd1);
        tick();
        chk("buf_gone", {31'b0, ms_to_ws_valid}, 32'd0);
        chk("buf_got_clr", {31'b0, dut.data_got}, 32'd0);

        // flush with a load outstanding; its response must be dropped
        issue(32'h110, 32'h4000, 1'b1, 1'b1, 5'b00100, 1'b0);
        ms_flush = 1'b1;
        settle();
        chk("fl_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        tick();
        ms_flush = 1'b0;
        chk("fl_cnt1", {30'b0, dut.cancel_cnt}, 32'd1);
        chk("fl_allowin", {31'b0, ms_allowin}, 32'd1);
        issue(32'h114, 32'h5000, 1'b1, 1'b1, 5'b00100, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11111111;
        settle();
        chk("fl_drop", {31'b0, ms_to_ws_valid}, 32'd0);
        tick();
        chk("fl_cnt0", {30'b0, dut.cancel_cnt}, 32'd0);
        data_sram_rdata = 32'h22222222;
        settle();
        chk("fl_deliver", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("fl_result", ms_final_result, 32'h22222222);
        tick();
        data_sram_data_ok = 1'b0;

        // store waits for data_ok, result is the address
        issue(32'h118, 32'h6004, 1'b1, 1'b0, 5'b00000, 1'b0);
        settle();
        chk("st_wait", {31'b0, ms_to_ws_valid}, 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h99999999;
        settle();
        chk("st_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("st_result", ms_final_result, 32'h6004);
        tick();
        data_sram_data_ok = 1'b0;

        // ALU passthrough
        issue(32'h11C, 32'h12345678, 1'b0, 1'b0, 5'b00000, 1'b0);
        settle();
        chk("alu_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        chk("alu_result", ms_final_result, 32'h12345678);
`ifdef MS_FWD_EN
        chk("alu_fwd", {31'b0, ms_fwd_valid}, 32'd1);
        chk("alu_fwd_data", ms_fwd_data, 32'h12345678);
        chk("alu_blk", {31'b0, ms_blk_valid}, 32'd0);
`else
        chk("alu_fwd_off", {31'b0, ms_fwd_valid}, 32'd0);
        chk("alu_blk_on", {31'b0, ms_blk_valid}, 32'd1);
`endif
        tick();

        // excepting load never waits
        issue(32'h120, 32'h7000, 1'b1, 1'b1, 5'b00100, 1'b1);
        settle();
        chk("ex_flag", {31'b0, ms_ex}, 32'd1);
        chk("ex_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        tick();
        chk("ex_clear", {31'b0, ms_ex}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access pipeline stage, directly downstream of the EXE stage and upstream of WB.
- Accepts the EXE result and, for loads/stores, the fact that EXE already completed the address handshake.
- Waits for `data_sram_data_ok`, then aligns and extends load data by op/address and hands the final result to WB.
- Discards stale responses after a pipeline flush and drives the forward/block bus seen by decode.

Parameters:
- DW, 32, data/address width.
- RW, 5, destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- es_to_ms_valid  in  1  EXE has a valid instruction for this stage.
- ms_allowin  out  1  stage can accept a new instruction this cycle.
- es_pc  in  DW  instruction PC.
- es_dest  in  RW  destination register.
- es_gr_we  in  1  register write enable.
- es_res_from_mem  in  1  instruction is a load.
- es_mem_req  in  1  EXE issued a memory request (addr_ok seen).
- es_load_op  in  5  one-hot: [0]ld.b [1]ld.h [2]ld.w [3]ld.bu [4]ld.hu.
- es_result  in  DW  ALU/mul/div result; equals vaddr for memory ops.
- es_ex  in  1  exception already raised upstream.
- data_sram_data_ok  in  1  response beat.
- data_sram_rdata  in  DW  response data.
- ms_flush  in  1  pipeline flush from WB.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  valid toward WB.
- ms_pc  out  DW  registered PC.
- ms_dest  out  RW  registered destination.
- ms_gr_we  out  1  registered write enable.
- ms_final_result  out  DW  load-extended or passthrough result.
- ms_ex  out  1  exception flag, qualified by valid.
- ms_fwd_valid  out  1  forward data is usable.
- ms_blk_valid  out  1  decode must stall (load data not yet back).
- ms_fwd_dest  out  RW  forward destination.
- ms_fwd_data  out  DW  forward value.

Behaviour:
- **Reset values.** Synchronous, active-high `reset`; clock `clk`. At reset: `ms_valid`=0, `data_got`=0, `data_buf`=0, `cancel_cnt`=0, every registered field=0. All outputs are 0 except `ms_allowin`=1.
- **Capture from EXE.** `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
  - On `es_to_ms_valid && ms_allowin`: latch all `es_*` fields, set `ms_valid`=1, clear `data_got`.
  - If `ms_allowin` is high with no valid input, `ms_valid` goes to 0.
- **Ready.** `ms_ready_go = !mem_req_r || ms_ex_r || data_got || (data_sram_data_ok && cancel_cnt==0)`.
  - `ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush`.
- **Response buffer.**
  - When `data_sram_data_ok`, `cancel_cnt`==0, `ms_valid`, `mem_req_r`, `!data_got` and `!ws_allowin`: set `data_got`=1 and `data_buf`=`rdata`.
  - `data_got` clears when the instruction leaves the stage or on flush.
  - Effective load data = `data_got ? data_buf : data_sram_rdata`.
- **Flush.** On `ms_flush`, `ms_valid`<=0 next cycle.
  - If `ms_valid && mem_req_r && !data_got && !data_sram_data_ok` at flush, `cancel_cnt` increments.
  - Also increment if `es_to_ms_valid && es_mem_req` in the same cycle, because EXE may have issued.
  - A `data_ok` with `cancel_cnt`>0 is consumed silently and decrements `cancel_cnt`.
  - A simultaneous increment and decrement leaves `cancel_cnt` unchanged.
  - `cancel_cnt` is 2 bits and saturates at 3.
- **Load extension.** `a = result_r[1:0]`.
  - b/bu select `byte[a]`.
  - h/hu select `half[a[1]]`.
  - w is a passthrough.
  - b/h sign-extend; bu/hu zero-extend.
  - Misaligned h/w never reach here with `mem_req_r`=1 (ALE is raised upstream).
  - `ms_final_result = res_from_mem_r ? extended : result_r`.
- **Exception.** `ms_ex = ms_valid && es_ex_r`. An excepting instruction never waits for `data_ok`.
- **Stores.** `mem_req_r && !res_from_mem_r`: the stage waits for `data_ok` but does not use `rdata`.
- **Reset mid-transaction.** `cancel_cnt` clears. The memory side is reset together with the core, so no stale beat arrives after reset.

Optional Feature:
- Macro `MS_FWD_EN`.
- Defined:
  - `ms_fwd_valid = ms_to_ws_valid && ms_gr_we`.
  - `ms_blk_valid = ms_valid && res_from_mem_r && !ms_ready_go`.
  - `ms_fwd_dest = ms_dest`.
  - `ms_fwd_data = ms_final_result`.
- Undefined:
  - `ms_fwd_valid`=0 and `ms_fwd_data`=0.
  - `ms_blk_valid = ms_valid && ms_gr_we`, so any valid writer stalls decode.
  - `ms_fwd_dest = ms_dest`.

Test Plan:
- **ld.b sign extend.** `result_r`=0x1003, ld.b; `data_ok` 2 cycles later with `rdata`=0x80112233, `ws_allowin`=1 → `ms_final_result`=0xFFFFFF80; `ms_to_ws_valid` high only in the `data_ok` cycle.
- **ld.hu zero extend.** `addr[1:0]`=2, `rdata`=0xBEEF1234 → `ms_final_result`=0x0000BEEF.
- **Buffered response.** `data_ok` with `rdata`=0xCAFEF00D while `ws_allowin`=0 for 3 cycles → `ms_final_result` holds 0xCAFEF00D and `ms_to_ws_valid` stays 1 until accept; `data_got` then clears.
- **Flush with request outstanding.** Flush with a load outstanding; next instruction is ld.w; first `data_ok` (0x11111111) is dropped, second (0x22222222) is delivered → result=0x22222222, `cancel_cnt` back to 0.
- **Non-memory passthrough and exception.** ALU op with `es_result`=0x12345678 → `ms_to_ws_valid` on the cycle after capture, result 0x12345678. With `es_ex`=1 → `ms_ex`=1 and no wait.
- **Forward bus.** With `MS_FWD_EN`: pending load gives `ms_blk_valid`=1 and `ms_fwd_valid`=0; after `data_ok`, `ms_fwd_valid`=1 with correct data. Without the macro: `ms_fwd_valid`=0 always.
